sonar_serial_deserializer: RTL and testbench
============================================

// Module: sonar_serial_deserializer
// PURPOSE
//  Multi-channel serial-to-parallel capture for the SONAR ADC front end.
//  Shifts CHANNELS serial bit streams in lock-step on a bit-enable strobe and frames WIDTH-bit words.
//  Presents each completed word set on a valid/ready holding register, with overrun and resync flags.
//  Sits between the ADC serial pins (already synchronised) and the sample FIFO / correlator.
// PARAMETERS
//  WIDTH       16  bits per word per channel (>=2)
//  CHANNELS    4   parallel serial inputs sharing one frame/enable (>=1)
//  MSB_FIRST   1   1: first bit received lands in q bit WIDTH-1; 0: first bit lands in bit 0
//  CONTINUOUS  0   1: next word starts on next enable after completion without frame; 0: each word needs frame
//  CW          $clog2(WIDTH+1) (localparam) width of bit_count
// PORTS
//  clk        in   1               system clock, all logic on rising edge
//  reset      in   1               synchronous, active-high; one clock; dominates every other input
//  enable     in   1               bit strobe: d and frame sampled only on cycles where enable=1
//  frame      in   1               word start marker, valid only with enable=1
//  d          in   CHANNELS        serial data, bit c = channel c
//  q          out  CHANNELS*WIDTH  held words, channel c at q[c*WIDTH +: WIDTH]
//  valid      out  1               q holds an unconsumed word set
//  ready      in   1               consumer accepts q on clk edge where valid&&ready
//  overrun    out  1               sticky: a completed word set was dropped
//  sync_err   out  1               one-cycle pulse: frame arrived mid-word, partial word discarded
//  bit_count  out  CW              bits captured in current word (0 when idle)
// BEHAVIOUR
//  Reset: state=IDLE, shift regs=0, q=0, valid=0, overrun=0, sync_err=0, bit_count=0.
//  enable=0: shift regs, state, bit_count hold; only handshake logic acts (valid&&ready clears valid).
//  Shift: MSB_FIRST=1 sr_c <= {sr_c[WIDTH-2:0], d[c]}; MSB_FIRST=0 sr_c <= {d[c], sr_c[WIDTH-1:1]}.
//  FSM states:
//   IDLE : enable&&frame -> capture bit 1, bit_count=1, go SHIFT; enable w/o frame ignored (CONTINUOUS=0).
//   SHIFT: enable&&!frame -> shift, bit_count+1. enable&&frame -> discard partial, capture as bit 1,
//          bit_count=1, sync_err=1 next cycle; stay SHIFT.
//   Completion: enable cycle capturing bit WIDTH (bit_count==WIDTH-1, frame=0):
//          word = sr updated with that bit; bit_count -> 0; next state IDLE (CONTINUOUS=0) or ARMED (=1).
//   ARMED (CONTINUOUS=1 only): any enable -> capture bit 1 (frame allowed, no sync_err), go SHIFT.
//  Latency: q/valid update on the same edge that samples the final bit; valid high the following cycle.
//  Handshake: q stable while valid=1; valid drops on edge with valid&&ready and no new completion.
//   completion && (!valid || ready)  -> q <= word, valid=1 (back-to-back accept: valid stays 1, no gap).
//   completion && valid && !ready    -> word dropped, q unchanged, overrun <= 1 (cleared only by reset).
//  sync_err is high exactly one cycle per mid-word frame; overrun and sync_err are independent.
//  frame without enable: ignored in all states. d sampled only with enable.
//  Reset mid-word or with valid=1: partial and held word lost, all outputs to reset values next cycle.
//  bit_count never exceeds WIDTH-1 while in SHIFT; no wrap beyond WIDTH.
// TESTING
//  1 WIDTH=16, CH=4, MSB_FIRST=1: frame+16 enabled bits 0xA5C3/0x1234/0xFFFF/0x0001, ready=1
//    -> valid 1 cycle, q channels match exactly, bit_count 1..15 then 0.
//  2 MSB_FIRST=0, same stream -> each channel word bit-reversed (0xA5C3 -> 0xC3A5); enable gaps of 0-3
//    idle cycles between bits do not change result.
//  3 ready=0, two complete words -> first word held in q, valid=1, overrun=1 after second; ready=1 ->
//    valid=0 next cycle, q = first word.
//  4 frame re-asserted at bit 7 of a word -> sync_err one-cycle pulse, next 16 bits form clean word, no overrun.
//  5 CONTINUOUS=1, one frame then 48 enabled bits, ready=1 -> three valid pulses with correct words;
//    CONTINUOUS=0 same stimulus -> one word only, bit_count stays 0 afterwards.
//  6 reset asserted at bit 9 with valid=1 -> next cycle valid=0, q=0, bit_count=0, overrun=0; enable w/o frame ignored.

Source files
------------

// File: rtl/sonar_serial_deserializer_if.sv
// Purpose: bundles the serial-capture input strobes and the held-word valid/ready outputs.
// Latency: none, wiring only.
// Backpressure: ready travels from the consumer back to the deserializer; other signals flow forward.
interface sonar_serial_deserializer_if #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4
);
    localparam int CW = $clog2(WIDTH + 1);

    logic                      enable;
    logic                      frame;
    logic [CHANNELS-1:0]       d;
    logic [CHANNELS*WIDTH-1:0] q;
    logic                      valid;
    logic                      ready;
    logic                      overrun;
    logic                      sync_err;
    logic [CW-1:0]             bit_count;

    // Source side: drives the serial strobes and the consumer ready.
    modport master (
        output enable, frame, d, ready,
        input  q, valid, overrun, sync_err, bit_count
    );

    // Deserializer side.
    modport slave (
        input  enable, frame, d, ready,
        output q, valid, overrun, sync_err, bit_count
    );
endinterface

// File: rtl/sonar_serial_deserializer.sv
// Purpose: lock-step multi-channel serial-to-parallel capture with frame sync, overrun and resync flags.
// Latency: q/valid load on the edge that samples the last bit of a word; valid is seen the next cycle.
// Backpressure: q is held while valid && !ready; a word completing then is dropped and overrun sticks.
module sonar_serial_deserializer #(
    parameter int WIDTH      = 16,
    parameter int CHANNELS   = 4,
    parameter bit MSB_FIRST  = 1'b1,
    parameter bit CONTINUOUS = 1'b0
) (
    input  logic                       clk,
    input  logic                       reset,
    sonar_serial_deserializer_if.slave bus
);
    localparam int            CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        ARMED = 2'd2
    } state_t;

    state_t                    state;
    logic [WIDTH-1:0]          sr       [CHANNELS];
    logic [WIDTH-1:0]          sr_shift [CHANNELS];
    logic [WIDTH-1:0]          sr_first [CHANNELS];
    logic [CHANNELS*WIDTH-1:0] word;

    logic [CHANNELS*WIDTH-1:0] q_r;
    logic                      valid_r;
    logic                      overrun_r;
    logic                      sync_err_r;
    logic [CW-1:0]             bit_count_r;

    // Per-strobe event decode: new word start, mid-word resync, plain shift, or final bit.
    logic start;
    logic resync;
    logic advance;
    logic complete;

    // Classify the current enabled cycle; nothing happens on cycles without enable.
    always_comb begin
        start    = 1'b0;
        resync   = 1'b0;
        advance  = 1'b0;
        complete = 1'b0;
        if (bus.enable) begin
            case (state)
                IDLE:  start = bus.frame;
                ARMED: start = 1'b1;
                SHIFT: begin
                    if (bus.frame) begin
                        resync = 1'b1;
                    end else if (bit_count_r == LAST) begin
                        complete = 1'b1;
                    end else begin
                        advance = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Next shift-register values per channel: shifted-in bit, or a fresh word seeded with bit 1.
    always_comb begin
        word = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (MSB_FIRST) begin
                sr_shift[c] = {sr[c][WIDTH-2:0], bus.d[c]};
                sr_first[c] = {{(WIDTH-1){1'b0}}, bus.d[c]};
            end else begin
                sr_shift[c] = {bus.d[c], sr[c][WIDTH-1:1]};
                sr_first[c] = {bus.d[c], {(WIDTH-1){1'b0}}};
            end
            word[c*WIDTH +: WIDTH] = sr_shift[c];
        end
    end

    // Framing FSM, shift registers and the valid/ready holding register, all registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            q_r         <= '0;
            valid_r     <= 1'b0;
            overrun_r   <= 1'b0;
            sync_err_r  <= 1'b0;
            bit_count_r <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                sr[c] <= '0;
            end
        end else begin
            sync_err_r <= 1'b0;

            // Consumer take; a completion below on the same edge re-asserts valid.
            if (valid_r && bus.ready) begin
                valid_r <= 1'b0;
            end

            // Start or restart a word: any partial bits are thrown away.
            if (start || resync) begin
                for (int c = 0; c < CHANNELS; c++) begin
                    sr[c] <= sr_first[c];
                end
                bit_count_r <= ONE;
                state       <= SHIFT;
            end

            if (resync) begin
                sync_err_r <= 1'b1;
            end

            if (advance) begin
                for (int c = 0; c < CHANNELS; c++) begin
                    sr[c] <= sr_shift[c];
                end
                bit_count_r <= bit_count_r + ONE;
            end

            // Final bit: hand the word over if the holding register is free, else drop it.
            if (complete) begin
                for (int c = 0; c < CHANNELS; c++) begin
                    sr[c] <= sr_shift[c];
                end
                bit_count_r <= '0;
                state       <= CONTINUOUS ? ARMED : IDLE;
                if (!valid_r || bus.ready) begin
                    q_r     <= word;
                    valid_r <= 1'b1;
                end else begin
                    overrun_r <= 1'b1;
                end
            end
        end
    end

    assign bus.q         = q_r;
    assign bus.valid     = valid_r;
    assign bus.overrun   = overrun_r;
    assign bus.sync_err  = sync_err_r;
    assign bus.bit_count = bit_count_r;

endmodule

// File: tb/tb_sonar_serial_deserializer.sv
// Purpose: directed check of framing, bit order, continuous mode, backpressure, resync and reset.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: ready driven per test to exercise hold and overrun.
module tb_sonar_serial_deserializer;
    localparam int W  = 16;
    localparam int CH = 4;
    localparam int CW = $clog2(W + 1);

    // Word sets, channel c at [c*W +: W]; *_REV is the LSB-first view of the same stream.
    localparam logic [63:0] W1     = {16'h0001, 16'hFFFF, 16'h1234, 16'hA5C3};
    localparam logic [63:0] W1_REV = {16'h8000, 16'hFFFF, 16'h2C48, 16'hC3A5};
    localparam logic [63:0] W2     = {16'hAAAA, 16'h5555, 16'hF0F0, 16'h0F0F};
    localparam logic [63:0] W3     = {16'h8001, 16'h7FFE, 16'hDEAD, 16'hBEEF};

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic          frame;
    logic          ready;
    logic [CH-1:0] d;

    int checks   = 0;
    int failures = 0;

    bit          mon = 1'b0;
    int          a_cnt = 0;
    int          c_cnt = 0;
    int          a_bc_bad = 0;
    logic [63:0] c_q[$];

    always #5 clk = ~clk;

    // a: MSB first, framed; b: LSB first, framed; c: MSB first, continuous.
    sonar_serial_deserializer_if #(.WIDTH(W), .CHANNELS(CH)) ia ();
    sonar_serial_deserializer_if #(.WIDTH(W), .CHANNELS(CH)) ib ();
    sonar_serial_deserializer_if #(.WIDTH(W), .CHANNELS(CH)) ic ();

    assign ia.enable = enable;
    assign ia.frame  = frame;
    assign ia.d      = d;
    assign ia.ready  = ready;
    assign ib.enable = enable;
    assign ib.frame  = frame;
    assign ib.d      = d;
    assign ib.ready  = ready;
    assign ic.enable = enable;
    assign ic.frame  = frame;
    assign ic.d      = d;
    assign ic.ready  = ready;

    sonar_serial_deserializer #(.WIDTH(W), .CHANNELS(CH), .MSB_FIRST(1'b1), .CONTINUOUS(1'b0))
        dut_a (.clk(clk), .reset(reset), .bus(ia));
    sonar_serial_deserializer #(.WIDTH(W), .CHANNELS(CH), .MSB_FIRST(1'b0), .CONTINUOUS(1'b0))
        dut_b (.clk(clk), .reset(reset), .bus(ib));
    sonar_serial_deserializer #(.WIDTH(W), .CHANNELS(CH), .MSB_FIRST(1'b1), .CONTINUOUS(1'b1))
        dut_c (.clk(clk), .reset(reset), .bus(ic));

    typedef struct {
        logic          en;
        logic          fr;
        logic [CH-1:0] dd;
        logic          rdy;
        logic [CW-1:0] exp_bc;
        logic          exp_vld;
    } vec_t;

    vec_t tv[18];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // One clock with current inputs; outputs settle and are observed 1 unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        if (mon) begin
            if (ic.valid) begin
                c_cnt++;
                c_q.push_back(ic.q);
            end
            if (a_cnt > 0 && ia.bit_count != '0) a_bc_bad++;
            if (ia.valid) a_cnt++;
        end
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        enable = 1'b1;
        frame  = 1'b1;
        d      = '1;
        step();
        reset  = 1'b0;
        enable = 1'b0;
        frame  = 1'b0;
        d      = '0;
    endtask

    // Send stream bits [first,last) of word set ws, MSB of each channel first on the wire.
    task automatic send(input logic [63:0] ws, input int first, input int last,
                        input bit fr, input bit gaps);
        for (int i = first; i < last; i++) begin
            enable = 1'b1;
            frame  = fr && (i == first);
            for (int c = 0; c < CH; c++) d[c] = ws[c*W + W-1-i];
            step();
            if (gaps) begin
                for (int g = 0; g < (i % 4); g++) begin
                    enable = 1'b0;
                    frame  = 1'b1;
                    d      = CH'($urandom);
                    step();
                end
            end
        end
        enable = 1'b0;
        frame  = 1'b0;
    endtask

    initial begin
        reset = 1'b0; enable = 1'b0; frame = 1'b0; ready = 1'b1; d = '0;

        // Test 1 vectors: frame + 16 bits of W1 with ready high, then idle and a stray enable.
        for (int i = 0; i < 16; i++) begin
            tv[i].en  = 1'b1;
            tv[i].fr  = (i == 0);
            for (int c = 0; c < CH; c++) tv[i].dd[c] = W1[c*W + W-1-i];
            tv[i].rdy     = 1'b1;
            tv[i].exp_bc  = (i == 15) ? CW'(0) : CW'(i + 1);
            tv[i].exp_vld = (i == 15);
        end
        tv[16].en = 1'b0; tv[16].fr = 1'b0; tv[16].dd = '0; tv[16].rdy = 1'b1;
        tv[16].exp_bc = '0; tv[16].exp_vld = 1'b0;
        tv[17].en = 1'b1; tv[17].fr = 1'b0; tv[17].dd = '1; tv[17].rdy = 1'b1;
        tv[17].exp_bc = '0; tv[17].exp_vld = 1'b0;

        // Reset state, reset applied with enable and frame high.
        do_reset();
        chk("rst_a_q", ia.q, 64'h0);
        chk("rst_a_valid", 64'(ia.valid), 64'h0);
        chk("rst_a_bc", 64'(ia.bit_count), 64'h0);
        chk("rst_a_overrun", 64'(ia.overrun), 64'h0);
        chk("rst_a_sync_err", 64'(ia.sync_err), 64'h0);
        chk("rst_b_valid", 64'(ib.valid), 64'h0);
        chk("rst_c_q", ic.q, 64'h0);

        // Test 1: table-driven MSB-first capture.
        for (int i = 0; i < 18; i++) begin
            enable = tv[i].en;
            frame  = tv[i].fr;
            d      = tv[i].dd;
            ready  = tv[i].rdy;
            step();
            chk($sformatf("t1_bc[%0d]", i), 64'(ia.bit_count), 64'(tv[i].exp_bc));
            chk($sformatf("t1_valid[%0d]", i), 64'(ia.valid), 64'(tv[i].exp_vld));
        end
        enable = 1'b0;
        chk("t1_a_q", ia.q, W1);
        chk("t1_b_q_rev", ib.q, W1_REV);
        chk("t1_a_overrun", 64'(ia.overrun), 64'h0);

        // Test 2: LSB-first with 0-3 idle cycles between bits (stray frame/d while disabled).
        do_reset();
        ready = 1'b1;
        send(W1, 0, 16, 1'b1, 1'b1);
        chk("t2_b_q_rev", ib.q, W1_REV);
        chk("t2_a_q", ia.q, W1);
        chk("t2_b_overrun", 64'(ib.overrun), 64'h0);
        chk("t2_b_sync_err", 64'(ib.sync_err), 64'h0);

        // Test 3: backpressure, second word dropped.
        do_reset();
        ready = 1'b0;
        send(W1, 0, 16, 1'b1, 1'b0);
        chk("t3_valid1", 64'(ia.valid), 64'h1);
        chk("t3_q1", ia.q, W1);
        chk("t3_overrun1", 64'(ia.overrun), 64'h0);
        send(W2, 0, 16, 1'b1, 1'b0);
        chk("t3_valid2", 64'(ia.valid), 64'h1);
        chk("t3_q2_held", ia.q, W1);
        chk("t3_overrun2", 64'(ia.overrun), 64'h1);
        ready = 1'b1;
        step();
        chk("t3_valid_drop", 64'(ia.valid), 64'h0);
        chk("t3_q_after", ia.q, W1);
        chk("t3_overrun_sticky", 64'(ia.overrun), 64'h1);

        // Test 4: frame re-asserted after 7 bits.
        do_reset();
        ready = 1'b1;
        send(W2, 0, 7, 1'b1, 1'b0);
        chk("t4_bc_pre", 64'(ia.bit_count), 64'd7);
        chk("t4_se_pre", 64'(ia.sync_err), 64'h0);
        send(W1, 0, 1, 1'b1, 1'b0);
        chk("t4_se_pulse", 64'(ia.sync_err), 64'h1);
        chk("t4_bc_restart", 64'(ia.bit_count), 64'd1);
        send(W1, 1, 2, 1'b0, 1'b0);
        chk("t4_se_gone", 64'(ia.sync_err), 64'h0);
        chk("t4_bc2", 64'(ia.bit_count), 64'd2);
        send(W1, 2, 16, 1'b0, 1'b0);
        chk("t4_valid", 64'(ia.valid), 64'h1);
        chk("t4_q", ia.q, W1);
        chk("t4_overrun", 64'(ia.overrun), 64'h0);

        // Test 5: one frame then 48 bits; continuous gives three words, framed gives one.
        do_reset();
        ready = 1'b1;
        a_cnt = 0; c_cnt = 0; a_bc_bad = 0;
        c_q.delete();
        mon = 1'b1;
        send(W1, 0, 16, 1'b1, 1'b0);
        send(W2, 0, 16, 1'b0, 1'b0);
        send(W3, 0, 16, 1'b0, 1'b0);
        step();
        step();
        mon = 1'b0;
        chk("t5_c_pulses", 64'(c_cnt), 64'd3);
        chk("t5_c_w0", (c_q.size() > 0) ? c_q[0] : 64'h0, W1);
        chk("t5_c_w1", (c_q.size() > 1) ? c_q[1] : 64'h0, W2);
        chk("t5_c_w2", (c_q.size() > 2) ? c_q[2] : 64'h0, W3);
        chk("t5_a_pulses", 64'(a_cnt), 64'd1);
        chk("t5_a_bc_stays0", 64'(a_bc_bad), 64'd0);
        chk("t5_a_q", ia.q, W1);

        // Test 6: reset mid-word with a held word and overrun set.
        do_reset();
        ready = 1'b0;
        send(W1, 0, 16, 1'b1, 1'b0);
        send(W2, 0, 16, 1'b1, 1'b0);
        send(W3, 0, 9, 1'b1, 1'b0);
        chk("t6_pre_valid", 64'(ia.valid), 64'h1);
        chk("t6_pre_overrun", 64'(ia.overrun), 64'h1);
        chk("t6_pre_bc", 64'(ia.bit_count), 64'd9);
        do_reset();
        chk("t6_valid", 64'(ia.valid), 64'h0);
        chk("t6_q", ia.q, 64'h0);
        chk("t6_bc", 64'(ia.bit_count), 64'h0);
        chk("t6_overrun", 64'(ia.overrun), 64'h0);
        chk("t6_c_q", ic.q, 64'h0);
        enable = 1'b1;
        frame  = 1'b0;
        d      = '1;
        for (int k = 0; k < 3; k++) step();
        enable = 1'b0;
        chk("t6_noframe_bc_a", 64'(ia.bit_count), 64'h0);
        chk("t6_noframe_bc_c", 64'(ic.bit_count), 64'h0);
        chk("t6_noframe_valid", 64'(ia.valid), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
